// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared core types and writeback arbiter defaults
package writeback_arbiter_pkg;

    localparam int XLEN             = 32;
    localparam int REG_IDX_W        = 5;
    localparam int NUM_REGS         = 32;
    localparam int FIFO_DEPTH_DEF   = 2;
    localparam int STARVE_LIMIT_DEF = 8;

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // One buffered multi-cycle result: destination register plus data.
    typedef struct packed {
        reg_idx_t rd;
        word_t    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - in-order buffer for multi-cycle results awaiting writeback
module wb_result_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    wb_entry_t      r_mem [DEPTH];
    logic           w_do_push;
    logic           w_do_pop;

    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign full_o    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    // A push into a full buffer is fine when the head leaves in the same cycle.
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign head_o    = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Advance read/write pointers; reset empties the buffer.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Payload storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= push_entry_i;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write port arbiter with pending scoreboard
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic     clk_i,
    input  logic     reset_i,
    input  logic     pipe_valid_i,
    input  reg_idx_t pipe_rd_i,
    input  word_t    pipe_data_i,
    input  logic     mc_issue_i,
    input  reg_idx_t mc_issue_rd_i,
    input  logic     mc_valid_i,
    input  reg_idx_t mc_rd_i,
    input  word_t    mc_data_i,
    output logic     mc_ready_o,
    input  reg_idx_t rs1_i,
    input  reg_idx_t rs2_i,
    output logic     stall_o,
    output logic     drain_req_o,
    output reg_idx_t write_register_o,
    output word_t    write_back_data_o,
    output logic     ctrl_write_back_o
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_starve_cnt;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    wb_entry_t           w_head;
    wb_entry_t           w_push_entry;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    // Held low in reset so upstream cannot hand us a result that would be dropped.
    assign mc_ready_o   = reset_i && !w_full;
    assign w_push       = mc_valid_i && mc_ready_o;
    // The pipeline owns the write port whenever it has a result.
    assign w_pop        = !w_empty && !pipe_valid_i;
    assign w_push_entry = '{rd: mc_rd_i, data: mc_data_i};

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .full_o       (w_full),
        .empty_o      (w_empty)
    );

    // Scoreboard set/clear masks; x0 is never tracked.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (mc_issue_i && mc_issue_rd_i != '0) w_set_mask[mc_issue_rd_i] = 1'b1;
        if (w_pop && w_head.rd != '0)          w_clr_mask[w_head.rd]     = 1'b1;
    end

    assign stall_o     = (r_pending[rs1_i] && rs1_i != '0) ||
                         (r_pending[rs2_i] && rs2_i != '0);
    assign drain_req_o = (r_starve_cnt == LIMIT_C);

    // Registered write port: pipeline first, then the buffer head, else idle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            write_register_o  <= '0;
            write_back_data_o <= '0;
            ctrl_write_back_o <= 1'b0;
        end else if (pipe_valid_i) begin
            write_register_o  <= pipe_rd_i;
            write_back_data_o <= pipe_data_i;
            ctrl_write_back_o <= (pipe_rd_i != '0);
        end else if (w_pop) begin
            write_register_o  <= w_head.rd;
            write_back_data_o <= w_head.data;
            ctrl_write_back_o <= (w_head.rd != '0);
        end else begin
            ctrl_write_back_o <= 1'b0;
        end
    end

    // Pending bits: a new issue wins over the commit of an older result.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_pending <= '0;
        else          r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end

    // Count cycles the head is held off by the pipeline, saturating at the limit.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)                                   r_starve_cnt <= '0;
        else if (w_empty || w_pop)                      r_starve_cnt <= '0;
        else if (pipe_valid_i && r_starve_cnt != LIMIT_C) r_starve_cnt <= r_starve_cnt + CNT_ONE;
    end

    // Issuing to a register whose older result is still outstanding is illegal.
    assert property (@(posedge clk_i) disable iff (!reset_i)
        !(mc_issue_i && mc_issue_rd_i != '0 && r_pending[mc_issue_rd_i] &&
          !w_clr_mask[mc_issue_rd_i]));

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: multi-cycle result buffer entries (power of two, at least 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: cycles a buffered result waits before drain_req_o asserts.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 pipe_valid_i / pipe_rd_i / pipe_data_i  input  1/5/word_t  in-order pipeline result; no handshake, always accepted.
REQ-006 mc_issue_i / mc_issue_rd_i  input  1/5  multi-cycle op issued; marks rd pending.
REQ-007 mc_valid_i / mc_rd_i / mc_data_i  input  1/5/word_t  multi-cycle result offer.
REQ-008 mc_ready_o  output  1  result accepted when mc_valid_i and mc_ready_o are both high.
REQ-009 rs1_i / rs2_i  input  5/5  decode-stage source registers for the hazard query.
REQ-010 stall_o  output  1  a nonzero source register is pending.
REQ-011 drain_req_o  output  1  request to upstream for one pipeline bubble.
REQ-012 write_register_o / write_back_data_o / ctrl_write_back_o  output  5/word_t/1  register-file write port.

Function
REQ-013 Write outputs SHALL be registered: a source selected in cycle N appears on the write port in cycle N+1.
REQ-014 A pipeline result SHALL have absolute priority; when pipe_valid_i=1, the pipeline result is committed.
REQ-015 The FIFO head SHALL commit only in cycles with pipe_valid_i=0; otherwise ctrl_write_back_o=0 next cycle.
REQ-016 Accepted mc results SHALL enter the FIFO in order; mc_ready_o = FIFO not full (no same-cycle full-bypass).
REQ-017 Simultaneous FIFO push and pop SHALL be legal in every state, including full, with occupancy unchanged.
REQ-018 A result with rd=0 SHALL produce ctrl_write_back_o=0; an mc result with rd=0 still consumes its FIFO entry.
REQ-019 The scoreboard SHALL hold 32 pending bits; bit 0 is never set.
REQ-020 A pending bit SHALL set on the edge after mc_issue_i; it SHALL clear on the edge the matching FIFO head is loaded into the write-port register.
REQ-021 When set and clear hit the same register in the same cycle, set SHALL win.
REQ-022 stall_o SHALL be combinational: (pending[rs1_i] and rs1_i!=0) or (pending[rs2_i] and rs2_i!=0); during the commit cycle the bit is already clear, and register-file forwarding supplies the data.
REQ-023 mc_issue_i to an already-pending rd SHALL be illegal; the bit stays set and a simulation assertion fires.
REQ-024 A starve counter SHALL count cycles with the FIFO non-empty and the head blocked by pipe_valid_i, saturating at STARVE_LIMIT.
REQ-025 The starve counter SHALL reset to 0 on any head pop or when the FIFO is empty.
REQ-026 drain_req_o SHALL be high while the starve counter equals STARVE_LIMIT.

Reset
REQ-027 On reset_i=0, asynchronously: FIFO empty, all pending bits 0, starve counter 0, ctrl_write_back_o=0, write_register_o=0, write_back_data_o=0.
REQ-028 While in reset: mc_ready_o=0, stall_o=0, drain_req_o=0.
REQ-029 A reset asserted mid-operation SHALL discard buffered results without emitting a write; mc_ready_o SHALL rise the first cycle after release.

Structure
REQ-030 word_t, the register-index width, and the register count SHALL come from the shared core package/defines; the FIFO_DEPTH and STARVE_LIMIT defaults SHALL be package constants.
REQ-031 The FIFO SHALL be a sub-module, wb_result_fifo: data+rd payload, push/pop, full/empty, simultaneous push/pop.
REQ-032 Scoreboard, arbitration and the starve counter SHALL live in writeback_arbiter.

Verification
REQ-033 Pipeline-only: pipe_valid_i=1, rd=5, data=0xDEADBEEF -> next cycle write_register_o=5, write_back_data_o=0xDEADBEEF, ctrl_write_back_o=1.
REQ-034 Contention: pipe (rd=3, 0x11) and mc (rd=7, 0x22) in the same cycle -> rd=3 committed at N+1; rd=7 committed the first cycle after pipe_valid_i drops; mc_ready_o stays 1.
REQ-035 Full: hold pipe_valid_i=1 and offer 3 mc results -> mc_ready_o=0 after 2 accepts; the third waits and is accepted on the first pop.
REQ-036 Scoreboard: issue rd=9; rs1_i=9 -> stall_o=1 until the rd=9 write commits; same-cycle re-issue of rd=9 at commit keeps stall_o=1.
REQ-037 Starvation: FIFO non-empty with pipe_valid_i=1 for 8 cycles -> drain_req_o=1 in cycle 9; drops after the bubble pops the head.
REQ-038 x0 and reset: mc result rd=0 -> no write, FIFO entry freed; reset with 2 entries buffered -> no write is ever emitted and FIFO is empty.
